// File: rtl/mx_block_quantizer_if.sv
// Handshake bundle for mx_block_quantizer: element input stream and parallel block output.
interface mx_block_quantizer_if #(
    parameter int k           = 4,
    parameter int in_width    = 18,
    parameter int bit_width   = 8,
    parameter int scale_width = 8
);
    logic                                i_valid;
    logic                                o_in_ready;
    logic signed [in_width-1:0]          i_val;
    logic signed [scale_width-1:0]       i_scale;
    logic                                o_valid;
    logic                                i_ready;
    logic [k-1:0][bit_width-1:0]         o_X;
    logic signed [scale_width-1:0]       o_S;

    modport slave (
        input  i_valid, i_val, i_scale, i_ready,
        output o_in_ready, o_valid, o_X, o_S
    );

    modport master (
        output i_valid, i_val, i_scale, i_ready,
        input  o_in_ready, o_valid, o_X, o_S
    );
endinterface

// File: rtl/mx_block_quantizer.sv
// Streaming MX re-quantizer: groups k fixed-point values into one block with a shared
// power-of-two scale and FP E/M element codes. Define MX_QUANT_RNE_EN for round-to-nearest-even.
module mx_block_quantizer #(
    parameter int k           = 4,
    parameter int in_width    = 18,
    parameter int exp_width   = 4,
    parameter int man_width   = 3,
    parameter int bit_width   = 1 + exp_width + man_width,
    parameter int scale_width = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mx_block_quantizer_if.slave  bus
);

    localparam int cnt_w    = (k > 1) ? $clog2(k) : 1;
    localparam int bias     = 2 ** (exp_width - 1) - 1;
    localparam int emax     = 2 ** exp_width - 1 - bias;
    localparam int ew       = scale_width + 2;
    localparam int mw       = exp_width + man_width;
    localparam int max_mag  = 2 ** mw - 1;
    localparam int man_mask = 2 ** man_width - 1;
    localparam logic signed [ew-1:0] s_hi = ew'(2 ** (scale_width - 1) - 1);
    localparam logic signed [ew-1:0] s_lo = ew'(-(2 ** (scale_width - 1)));

    if (bit_width != 1 + exp_width + man_width) begin : g_width_check
        $error("bit_width must equal 1+exp_width+man_width");
    end
    if (k < 2 || (k & (k - 1)) != 0) begin : g_k_check
        $error("k must be a power of two >= 2");
    end

    typedef enum logic [1:0] {COLLECT, NORM, QUANT, OUT} state_t;

    state_t                         state_q, state_d;
    logic signed [in_width-1:0]     elem_q [k];
    logic [cnt_w-1:0]               count_q;
    logic [in_width-1:0]            max_q;
    logic signed [scale_width-1:0]  scale_q;
    logic signed [scale_width-1:0]  s_q, s_norm;
    logic [k-1:0][bit_width-1:0]    x_q, x_next;
    logic signed [ew-1:0]           s_raw, sh;
    logic [in_width-1:0]            in_mag;
    logic                           in_ready, out_valid, accept;

    function automatic logic [in_width-1:0] abs_val(input logic signed [in_width-1:0] v);
        abs_val = v[in_width-1] ? -v : v;
    endfunction

    function automatic int msb_idx(input logic [in_width-1:0] v);
        int res;
        res = 0;
        for (int unsigned i = 0; i < in_width; i++) begin
            if (v[i]) res = int'(i);
        end
        return res;
    endfunction

    // Everything is expressed relative to the integer magnitude a: r is the weight of the
    // output LSB in a's bit positions, so normal and subnormal share one shift/round path.
    function automatic logic [bit_width-1:0] encode(input logic signed [in_width-1:0] v,
                                                    input int sh_amt);
        logic [in_width-1:0] a;
        logic [bit_width-1:0] res;
        int p, e, r, code, q, mag;
`ifdef MX_QUANT_RNE_EN
        logic guard, sticky, up;
`endif
        a   = abs_val(v);
        res = '0;
        if (a != '0) begin
            p = msb_idx(a);
            e = p + sh_amt;
            if (e > emax) begin
                mag = max_mag;
            end else begin
                if (e >= 1 - bias) begin
                    code = e + bias;
                    r    = p - man_width;
                end else begin
                    code = 0;
                    r    = 1 - bias - man_width - sh_amt;
                end
                if (r <= 0)             q = int'(a) << (-r);
                else if (r >= in_width) q = 0;
                else                    q = int'(a) >> r;
                mag = (code << man_width) | (q & man_mask);
`ifdef MX_QUANT_RNE_EN
                up = 1'b0;
                if (r >= 1 && r <= in_width) begin
                    guard  = ((int'(a) >> (r - 1)) & 1) != 0;
                    sticky = (int'(a) & ((1 << (r - 1)) - 1)) != 0;
                    up     = guard && (sticky || q[0]);
                end
                if (up) mag = mag + 1;
`endif
                if (mag > max_mag) mag = max_mag;
            end
            if (mag != 0) res = {v[in_width-1], mw'(mag)};
        end
        return res;
    endfunction

    assign in_mag = abs_val(bus.i_val);
    assign accept = (state_q == COLLECT) && bus.i_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= COLLECT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (accept && count_q == cnt_w'(k - 1)) state_d = NORM;
            end
            NORM:  state_d = QUANT;
            QUANT: state_d = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (bus.i_ready) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        s_raw = ew'(scale_q) + ew'(msb_idx(max_q)) - ew'(emax);
        if (max_q == '0)       s_norm = scale_q;
        else if (s_raw > s_hi) s_norm = scale_width'(s_hi);
        else if (s_raw < s_lo) s_norm = scale_width'(s_lo);
        else                   s_norm = scale_width'(s_raw);
    end

    always_comb begin
        x_next = '0;
        sh     = ew'(scale_q) - ew'(s_q);
        for (int unsigned i = 0; i < k; i++) begin
            x_next[i] = encode(elem_q[i], int'(sh));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < k; i++) elem_q[i] <= '0;
            count_q <= '0;
            max_q   <= '0;
            scale_q <= '0;
            s_q     <= '0;
            x_q     <= '0;
        end else begin
            if (accept) begin
                elem_q[count_q] <= bus.i_val;
                count_q         <= count_q + cnt_w'(1);
                if (count_q == '0) begin
                    scale_q <= bus.i_scale;
                    max_q   <= in_mag;
                end else if (in_mag > max_q) begin
                    max_q <= in_mag;
                end
            end
            if (state_q == NORM)  s_q <= s_norm;
            if (state_q == QUANT) x_q <= x_next;
        end
    end

    assign bus.o_in_ready = in_ready;
    assign bus.o_valid    = out_valid;
    assign bus.o_X        = x_q;
    assign bus.o_S        = s_q;

endmodule

// File: tb/tb_mx_block_quantizer.sv
// Directed-vector bench for mx_block_quantizer; expectations follow MX_QUANT_RNE_EN when defined.
module tb_mx_block_quantizer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mx_block_quantizer_if #(.k(4), .in_width(18), .bit_width(8), .scale_width(8)) bus ();

    mx_block_quantizer #(
        .k(4), .in_width(18), .exp_width(4), .man_width(3), .bit_width(8), .scale_width(8)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [31:0] scale;
        logic [3:0][31:0]   v;
        logic signed [31:0] s;
        logic [3:0][7:0]    x;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input int sc, input int a0, input int a1, input int a2,
                                input int a3, input int s, input int x0, input int x1,
                                input int x2, input int x3);
        vec_t t;
        t.scale = sc;
        t.v[0] = a0; t.v[1] = a1; t.v[2] = a2; t.v[3] = a3;
        t.s = s;
        t.x[0] = 8'(x0); t.x[1] = 8'(x1); t.x[2] = 8'(x2); t.x[3] = 8'(x3);
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input int v, input int s);
        int unsigned n;
        n = 0;
        bus.i_valid = 1'b1;
        bus.i_val   = 18'(v);
        bus.i_scale = 8'(s);
        while (!bus.o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: o_in_ready stayed 0");
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int unsigned n;
        n = 0;
        while (!bus.o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: o_valid never rose", tag);
        end
    endtask

    task automatic push_block(input vec_t t);
        for (int j = 0; j < 4; j++) push(int'(t.v[j]), int'(t.scale));
    endtask

    task automatic take_block(input string tag, input vec_t t);
        wait_valid(tag);
        check({tag, "_o_S"}, int'(bus.o_S), int'(t.s));
        for (int j = 0; j < 4; j++)
            check($sformatf("%s_o_X%0d", tag, j), int'(bus.o_X[j]), int'(t.x[j]));
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t fresh;
        checks   = 0;
        failures = 0;

        tbl[0] = mk(0, 8, 4, 2, 1, -5, 'h78, 'h70, 'h68, 'h60);
`ifdef MX_QUANT_RNE_EN
        tbl[1] = mk(0, -12, 0, 27, 31, -4, 'hF4, 'h00, 'h7E, 'h7F);
`else
        tbl[1] = mk(0, -12, 0, 27, 31, -4, 'hF4, 'h00, 'h7D, 'h7F);
`endif
        tbl[2] = mk(0, 65536, 3, 1, 0, 8, 'h78, 'h06, 'h02, 'h00);
        tbl[3] = mk(5, 0, 0, 0, 0, 5, 'h00, 'h00, 'h00, 'h00);
        tbl[4] = mk(120, 65536, 0, 0, 0, 127, 'h7F, 'h00, 'h00, 'h00);
        tbl[5] = mk(0, -131072, 1, -1, 0, 9, 'hF8, 'h01, 'h81, 'h00);
        tbl[6] = mk(-128, 1, 0, 0, 0, -128, 'h38, 'h00, 'h00, 'h00);
        tbl[7] = mk(3, 7, -5, 6, 1, -3, 'h7E, 'hFA, 'h7C, 'h68);
`ifdef MX_QUANT_RNE_EN
        tbl[8] = mk(0, 127, 9, -19, 100, -2, 'h7F, 'h61, 'hEA, 'h7C);
        tbl[9] = mk(0, 255, 31, 0, 0, -1, 'h7F, 'h68, 'h00, 'h00);
`else
        tbl[8] = mk(0, 127, 9, -19, 100, -2, 'h7F, 'h61, 'hE9, 'h7C);
        tbl[9] = mk(0, 255, 31, 0, 0, -1, 'h7F, 'h67, 'h00, 'h00);
`endif
        fresh = mk(2, 1, 2, 3, 4, -4, 'h68, 'h70, 'h74, 'h78);

        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_val   = '0;
        bus.i_scale = '0;
        bus.i_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_o_valid", int'(bus.o_valid), 0);
        check("rst_o_in_ready", int'(bus.o_in_ready), 1);
        check("rst_o_S", int'(bus.o_S), 0);
        check("rst_o_X", int'(bus.o_X), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            push_block(tbl[i]);
            if (i == 0) begin
                check("lat_edge0_o_valid", int'(bus.o_valid), 0);
                check("lat_edge0_o_in_ready", int'(bus.o_in_ready), 0);
                @(negedge clk);
                check("lat_edge1_o_valid", int'(bus.o_valid), 0);
                @(negedge clk);
                check("lat_edge2_o_valid", int'(bus.o_valid), 1);
            end
            take_block($sformatf("vec%0d", i), tbl[i]);
        end

        // Backpressure: hold i_ready low with a stray i_valid pending.
        push_block(tbl[0]);
        wait_valid("bp");
        bus.i_valid = 1'b1;
        bus.i_val   = 18'(999);
        bus.i_scale = 8'(7);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_o_valid", c), int'(bus.o_valid), 1);
            check($sformatf("bp%0d_o_in_ready", c), int'(bus.o_in_ready), 0);
            check($sformatf("bp%0d_o_S", c), int'(bus.o_S), int'(tbl[0].s));
            check($sformatf("bp%0d_o_X", c), int'(bus.o_X), int'(tbl[0].x));
        end
        bus.i_valid = 1'b0;
        take_block("bp_rel", tbl[0]);
        check("bp_after_o_valid", int'(bus.o_valid), 0);
        check("bp_after_o_in_ready", int'(bus.o_in_ready), 1);
        push_block(tbl[7]);
        take_block("bp_next", tbl[7]);

        // Reset while a block is presented.
        push_block(tbl[1]);
        wait_valid("rst_out");
        rst = 1'b1;
        #1;
        check("rst_out_o_valid", int'(bus.o_valid), 0);
        check("rst_out_o_in_ready", int'(bus.o_in_ready), 1);
        check("rst_out_o_S", int'(bus.o_S), 0);
        check("rst_out_o_X", int'(bus.o_X), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset after 2 of 4 elements; next 4 must form a fresh block.
        push(100, 50);
        push(200, 50);
        rst = 1'b1;
        #1;
        check("rst_mid_o_valid", int'(bus.o_valid), 0);
        check("rst_mid_o_in_ready", int'(bus.o_in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_block(fresh);
        take_block("rst_fresh", fresh);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
